mem_access_unit: RTL

Multi-cycle load/store initiator that sits between the MIPS datapath and the word-organised data memory. It accepts byte-addressed load and store requests of byte, halfword or word size and drives the memory port. The memory has an asynchronous read and a synchronous write. Sub-word loads are lane-selected and sign- or zero-extended. Sub-word stores are done as a read-modify-write of the containing word.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 63 ++++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access path: access sizes,
// load/store FSM states and the request legality check.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } state_t;

    // A request is illegal for a reserved size, a misaligned half or word,
    // or any sub-word size when sub-word support is not built in.
    function automatic logic req_illegal(input logic [1:0] size,
                                         input logic [1:0] addr_lo,
                                         input logic       subword_en);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = !subword_en;
            SZ_HALF: bad = !subword_en || addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane handling for sub-word accesses:
// load lane select with sign/zero extension, and store lane merge into
// the word read back from memory.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half lanes out of the memory word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full word; word loads pass through.
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~uns & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0: merge_data[7:0]   = wdata[7:0];
                    2'd1: merge_data[15:8]  = wdata[7:0];
                    2'd2: merge_data[23:16] = wdata[7:0];
                    2'd3: merge_data[31:24] = wdata[7:0];
                    default: merge_data = rdata;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
                else            merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator between the MIPS datapath and a
// word-organised memory (asynchronous read, synchronous write).
// Optional feature macro: MEM_ACCESS_SUBWORD_EN enables byte/half accesses
// (lane-selected loads, read-modify-write stores). Without it only word
// accesses are legal and the lane logic is not built.
// Handshake: a request is taken on a rising edge where i_req && o_ready;
// the unit then completes it with a one-cycle o_done pulse (o_err with it
// when the request was rejected). o_ready is high again in the o_done cycle.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [1:0]            o_dbg_state
);

`ifdef MEM_ACCESS_SUBWORD_EN
    localparam logic SUBWORD_EN = 1'b1;
`else
    localparam logic SUBWORD_EN = 1'b0;
`endif

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    bad_req;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    assign accept  = i_req && (state == ST_IDLE);
    assign bad_req = req_illegal(i_size, i_addr[1:0], SUBWORD_EN);

`ifdef MEM_ACCESS_SUBWORD_EN
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merge_data;
    logic                  unused_sub;

    mem_lane_align u_lane (
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .rdata      (i_mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign o_mem_wdata = (size_q == SZ_WORD) ? wdata_q : merge_q;
    assign unused_sub  = ^i_addr[31:ADDR_WIDTH+2];
`else
    logic unused_word;

    assign o_mem_wdata = wdata_q;
    assign unused_word = ^{i_unsigned, i_addr[31:ADDR_WIDTH+2], addr_q[1:0], size_q};
`endif

    assign o_ready     = (state == ST_IDLE);
    assign o_mem_we    = (state == ST_WR);
    assign o_mem_addr  = addr_q[ADDR_WIDTH+1:2];
    assign o_dbg_state = state;

    // State register; reset drops straight back to IDLE, killing any write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state decode: word stores skip the read, everything else reads first.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && !bad_req) begin
                    state_next = (i_we && (i_size == SZ_WORD)) ? ST_WR : ST_RD;
                end
            end
`ifdef MEM_ACCESS_SUBWORD_EN
            ST_RD:   state_next = we_q ? ST_WR : ST_IDLE;
`else
            ST_RD:   state_next = ST_IDLE;
`endif
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, load result, merge word and completion pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            o_rdata <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
            uns_q   <= 1'b0;
            merge_q <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (accept) begin
                addr_q  <= i_addr[ADDR_WIDTH+1:0];
                size_q  <= i_size;
                we_q    <= i_we;
                wdata_q <= i_wdata;
`ifdef MEM_ACCESS_SUBWORD_EN
                uns_q   <= i_unsigned;
`endif
                if (bad_req) begin
                    o_done <= 1'b1;
                    o_err  <= 1'b1;
                end
            end
            case (state)
                ST_RD: begin
                    if (!we_q) begin
`ifdef MEM_ACCESS_SUBWORD_EN
                        o_rdata <= load_data;
`else
                        o_rdata <= i_mem_rdata;
`endif
                        o_done  <= 1'b1;
                    end
`ifdef MEM_ACCESS_SUBWORD_EN
                    else begin
                        merge_q <= merge_data;
                    end
`endif
                end
                ST_WR:   o_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
